// File: rtl/fast_cmd_pkg.sv
// Shared fast-command definitions: 4-bit codes, 8-bit line symbols and the qinj FSM state type.
// Used by the scheduler, its qinj sequencer and the fast-command encoder.
package fast_cmd_pkg;

    typedef logic [3:0] fc_code_t;

    localparam fc_code_t FC_IDLE       = 4'd0;
    localparam fc_code_t FC_LINK_RESET = 4'd1;
    localparam fc_code_t FC_BCR        = 4'd2;
    localparam fc_code_t FC_STP        = 4'd3;
    localparam fc_code_t FC_L1ACR      = 4'd4;
    localparam fc_code_t FC_CHG_INJ    = 4'd5;
    localparam fc_code_t FC_L1A        = 4'd6;
    localparam fc_code_t FC_L1A_BCR    = 4'd7;
    localparam fc_code_t FC_WS_START   = 4'd8;
    localparam fc_code_t FC_WS_STOP    = 4'd9;

    localparam int ORBIT_LEN_DEF = 3564;
    localparam int BCNT_W_DEF    = 12;
    localparam int DLY_W_DEF     = 9;

    typedef enum logic [1:0] {
        Q_IDLE = 2'd0,
        Q_PEND = 2'd1,
        Q_WAIT = 2'd2
    } qinj_state_t;

    // DC-balanced 8-bit line symbols (four ones each); unknown codes map to idle.
    function automatic logic [7:0] fc_encode(input fc_code_t code);
        case (code)
            FC_IDLE:       fc_encode = 8'hAC;
            FC_LINK_RESET: fc_encode = 8'hB2;
            FC_BCR:        fc_encode = 8'h59;
            FC_STP:        fc_encode = 8'h4D;
            FC_L1ACR:      fc_encode = 8'h6A;
            FC_CHG_INJ:    fc_encode = 8'h93;
            FC_L1A:        fc_encode = 8'h2E;
            FC_L1A_BCR:    fc_encode = 8'h36;
            FC_WS_START:   fc_encode = 8'hC5;
            FC_WS_STOP:    fc_encode = 8'hD1;
            default:       fc_encode = 8'hAC;
        endcase
    endfunction

endpackage

// File: rtl/fast_cmd_scheduler_qinj.sv
// qinj_sequencer: holds a charge-injection request until granted, then times the follow-up L1A.
// Latency: dly_l1a_req asserts d cycles after the grant cycle (d = max(qinj_delay,1)).
// Backpressure: qi_req stays high until qi_grant; new qinj_req is ignored while busy.
module qinj_sequencer
    import fast_cmd_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF
) (
    input  logic             clk40,
    input  logic             rst,
    input  logic             enable,
    input  logic             qinj_req,
    input  logic [DLY_W-1:0] qinj_delay,
    input  logic             qi_grant,
    output logic             qi_req,
    output logic             dly_l1a_req,
    output logic             qinj_busy
);

    qinj_state_t      state, state_nxt;
    logic [DLY_W-1:0] dly_cnt, dly_cnt_nxt;
    logic [DLY_W-1:0] dly_lat, dly_lat_nxt;

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state   <= Q_IDLE;
            dly_cnt <= '0;
            dly_lat <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_cnt_nxt;
            dly_lat <= dly_lat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        dly_lat_nxt = dly_lat;
        qi_req      = 1'b0;
        dly_l1a_req = 1'b0;
        if (!enable) begin
            state_nxt   = Q_IDLE;
            dly_cnt_nxt = '0;
            dly_lat_nxt = '0;
        end else begin
            case (state)
                Q_IDLE: begin
                    if (qinj_req) begin
                        state_nxt   = Q_PEND;
                        // A zero delay would put the L1A on top of its own chargeInj.
                        dly_lat_nxt = (qinj_delay == '0) ? DLY_W'(1) : qinj_delay;
                    end
                end
                Q_PEND: begin
                    qi_req = 1'b1;
                    if (qi_grant) begin
                        dly_cnt_nxt = dly_lat;
                        state_nxt   = Q_WAIT;
                    end
                end
                Q_WAIT: begin
                    dly_cnt_nxt = dly_cnt - DLY_W'(1);
                    if (dly_cnt == DLY_W'(1)) begin
                        dly_l1a_req = 1'b1;
                        state_nxt   = Q_IDLE;
                    end
                end
                default: state_nxt = Q_IDLE;
            endcase
        end
    end

    assign qinj_busy = (state != Q_IDLE);

endmodule

// File: rtl/fast_cmd_scheduler.sv
// Per-BX fast-command arbiter (L1A > BCR > chargeInj > sw) plus local BX counter; FCS_STATS_EN adds L1A/merge counters.
// Latency: winner registered into cmd_out one cycle after its request; l1a_merged/sw_err aligned with cmd_out.
// Backpressure: sw_ready is combinational and high only in a cycle the software command wins the slot.
module fast_cmd_scheduler
    import fast_cmd_pkg::*;
#(
    parameter int ORBIT_LEN = ORBIT_LEN_DEF,
    parameter int BCNT_W    = BCNT_W_DEF,
    parameter int DLY_W     = DLY_W_DEF
) (
    input  logic              clk40,
    input  logic              rst,
    input  logic              enable,
    input  logic              trig,
    input  logic              bcr_en,
    input  logic [BCNT_W-1:0] bcr_offset,
    input  logic              qinj_req,
    input  logic [DLY_W-1:0]  qinj_delay,
    input  logic [3:0]        sw_cmd,
    input  logic              sw_valid,
    output logic              sw_ready,
    output fc_code_t          cmd_out,
    output logic [BCNT_W-1:0] bcnt,
    output logic              qinj_busy,
    output logic              l1a_merged,
    output logic              sw_err
`ifdef FCS_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       l1a_count,
    output logic [15:0]       merge_count
`endif
);

    logic     l1a_req, bcr_req, qi_req, qi_grant, dly_l1a_req;
    logic     merge_now, sw_bad;
    fc_code_t cmd_nxt;

    qinj_sequencer #(.DLY_W(DLY_W)) u_qinj (
        .clk40       (clk40),
        .rst         (rst),
        .enable      (enable),
        .qinj_req    (qinj_req),
        .qinj_delay  (qinj_delay),
        .qi_grant    (qi_grant),
        .qi_req      (qi_req),
        .dly_l1a_req (dly_l1a_req),
        .qinj_busy   (qinj_busy)
    );

    always_comb begin
        cmd_nxt   = FC_IDLE;
        qi_grant  = 1'b0;
        sw_ready  = 1'b0;
        merge_now = 1'b0;
        sw_bad    = 1'b0;
        l1a_req   = enable & (trig | dly_l1a_req);
        bcr_req   = enable & bcr_en & (bcnt == bcr_offset);
        if (l1a_req) begin
            // BCR never loses: it rides along with the L1A as L1A_BCR.
            cmd_nxt   = bcr_req ? FC_L1A_BCR : FC_L1A;
            merge_now = trig & dly_l1a_req;
        end else if (bcr_req) begin
            cmd_nxt = FC_BCR;
        end else if (qi_req) begin
            cmd_nxt  = FC_CHG_INJ;
            qi_grant = 1'b1;
        end else if (enable && sw_valid) begin
            sw_ready = 1'b1;
            if (sw_cmd > FC_WS_STOP) begin
                sw_bad = 1'b1;
            end else begin
                cmd_nxt = sw_cmd;
            end
        end
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            cmd_out    <= FC_IDLE;
            bcnt       <= '0;
            l1a_merged <= 1'b0;
            sw_err     <= 1'b0;
        end else begin
            cmd_out    <= cmd_nxt;
            l1a_merged <= merge_now;
            sw_err     <= sw_bad;
            if (!enable || bcnt == BCNT_W'(ORBIT_LEN - 1)) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

`ifdef FCS_STATS_EN
    // Counters survive enable toggles so a run can be paused without losing totals.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            l1a_count   <= '0;
            merge_count <= '0;
        end else if (stats_clr) begin
            l1a_count   <= '0;
            merge_count <= '0;
        end else begin
            if ((cmd_out == FC_L1A || cmd_out == FC_L1A_BCR) && l1a_count != 16'hFFFF) begin
                l1a_count <= l1a_count + 16'd1;
            end
            if (l1a_merged && merge_count != 16'hFFFF) begin
                merge_count <= merge_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fast_cmd_scheduler.sv
// Scoreboard bench for fast_cmd_scheduler: directed stimulus pushes expected commands, a monitor checks cmd_out.
// Define FCS_STATS_EN for both RTL and bench to cover the statistics counters.
module tb_fast_cmd_scheduler;
    import fast_cmd_pkg::*;

    logic        clk40 = 1'b0;
    logic        rst, enable, trig, bcr_en, qinj_req, sw_valid, sw_ready;
    logic [11:0] bcr_offset, bcnt;
    logic [8:0]  qinj_delay;
    logic [3:0]  sw_cmd, cmd_out;
    logic        qinj_busy, l1a_merged, sw_err;
`ifdef FCS_STATS_EN
    logic        stats_clr;
    logic [15:0] l1a_count, merge_count;
`endif

    fast_cmd_scheduler dut (
        .clk40      (clk40),
        .rst        (rst),
        .enable     (enable),
        .trig       (trig),
        .bcr_en     (bcr_en),
        .bcr_offset (bcr_offset),
        .qinj_req   (qinj_req),
        .qinj_delay (qinj_delay),
        .sw_cmd     (sw_cmd),
        .sw_valid   (sw_valid),
        .sw_ready   (sw_ready),
        .cmd_out    (cmd_out),
        .bcnt       (bcnt),
        .qinj_busy  (qinj_busy),
        .l1a_merged (l1a_merged),
        .sw_err     (sw_err)
`ifdef FCS_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .l1a_count   (l1a_count),
        .merge_count (merge_count)
`endif
    );

    always #5 clk40 = ~clk40;

    typedef struct {
        logic [3:0] code;
        int         at;
        bit         mrg;
        bit         err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_l1a_exp = 0;

    always @(posedge clk40) cyc <= cyc + 1;

    task automatic push(input logic [3:0] code, input int at, input bit mrg, input bit err);
        exp_t e;
        e.code = code; e.at = at; e.mrg = mrg; e.err = err;
        q.push_back(e);
        if (code == FC_L1A || code == FC_L1A_BCR) n_l1a_exp++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk40);
        #2;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Monitor: anything visible on the command side must match the head of the queue.
    always @(negedge clk40) begin
        if (q.size() > 0 && q[0].at < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_cmd: got nothing, required code %0d at cycle %0d", q[0].code, q[0].at);
            void'(q.pop_front());
        end
        if (cmd_out != 4'd0 || sw_err || l1a_merged) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd: got code %0d merged %0b err %0b at cycle %0d, required none",
                         cmd_out, l1a_merged, sw_err, cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.code !== cmd_out || mon_e.at != cyc || mon_e.mrg !== l1a_merged || mon_e.err !== sw_err) begin
                    n_bad++;
                    $display("FAIL cmd_out: got code %0d merged %0b err %0b at cycle %0d, required code %0d merged %0b err %0b at cycle %0d",
                             cmd_out, l1a_merged, sw_err, cyc, mon_e.code, mon_e.mrg, mon_e.err, mon_e.at);
                end
            end
        end
    end

    initial begin
        int k0, e0, c;
        rst = 1'b1; enable = 1'b0; trig = 1'b0; bcr_en = 1'b0; bcr_offset = '0;
        qinj_req = 1'b0; qinj_delay = '0; sw_cmd = '0; sw_valid = 1'b0;
`ifdef FCS_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_bcnt", bcnt, 0);
        chk("rst_qinj_busy", qinj_busy, 0);
        chk("rst_merged", l1a_merged, 0);
        chk("rst_sw_err", sw_err, 0);
        @(negedge clk40); #1; rst = 1'b0;
        step(); step();
        sw_valid = 1'b1; sw_cmd = FC_STP; #1;
        chk("disabled_sw_ready", sw_ready, 0);
        sw_valid = 1'b0;
        step();

        // Orbit wrap with BCR at the last BX of the orbit.
        bcr_en = 1'b1; bcr_offset = 12'd3563; enable = 1'b1; k0 = cyc;
        push(FC_BCR, k0 + 3564, 0, 0);
        push(FC_BCR, k0 + 2 * 3564, 0, 0);
        chk("first_bcnt", bcnt, 0);
        step_to(k0 + 3563);
        chk("bcnt_max", bcnt, 3563);
        step();
        chk("bcnt_wrap", bcnt, 0);
        step_to(k0 + 2 * 3564 + 3);

        // L1A and BCR in the same BX merge into L1A_BCR.
        enable = 1'b0; bcr_offset = 12'd100;
        step();
        enable = 1'b1; e0 = cyc;
        step_to(e0 + 50);
        trig = 1'b1; push(FC_L1A, cyc + 1, 0, 0);
        step(); trig = 1'b0;
        step_to(e0 + 100);
        chk("bcnt_100", bcnt, 100);
        trig = 1'b1; push(FC_L1A_BCR, cyc + 1, 0, 0);
        step(); trig = 1'b0; bcr_en = 1'b0;
        step(); step();

        // Charge injection with delay 20, then delay 0.
        c = cyc; qinj_req = 1'b1; qinj_delay = 9'd20; #1;
        chk("qbusy_before", qinj_busy, 0);
        push(FC_CHG_INJ, c + 2, 0, 0); push(FC_L1A, c + 22, 0, 0);
        step(); qinj_req = 1'b0;
        chk("qbusy_pend", qinj_busy, 1);
        step_to(c + 21);
        chk("qbusy_last", qinj_busy, 1);
        step();
        chk("qbusy_done", qinj_busy, 0);
        step_to(c + 25);
        c = cyc; qinj_req = 1'b1; qinj_delay = 9'd0;
        push(FC_CHG_INJ, c + 2, 0, 0); push(FC_L1A, c + 3, 0, 0);
        step(); qinj_req = 1'b0;
        step_to(c + 6);

        // Pending chargeInj waits behind trig; qinj_req while busy is ignored.
        c = cyc; qinj_req = 1'b1; qinj_delay = 9'd3;
        step(); qinj_req = 1'b0; trig = 1'b1; push(FC_L1A, c + 2, 0, 0);
        step(); qinj_req = 1'b1; qinj_delay = 9'd5; push(FC_L1A, c + 3, 0, 0);
        step(); qinj_req = 1'b0; trig = 1'b0;
        push(FC_CHG_INJ, c + 4, 0, 0); push(FC_L1A, c + 7, 0, 0);
        step_to(c + 10);
        chk("qbusy_idle_after_prio", qinj_busy, 0);

        // Software command held off by trig, then issued once.
        sw_valid = 1'b1; sw_cmd = FC_STP; trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(FC_L1A, cyc + 1, 0, 0);
            #1; chk("sw_blocked", sw_ready, 0);
            step();
        end
        trig = 1'b0; #1;
        chk("sw_granted", sw_ready, 1);
        push(FC_STP, cyc + 1, 0, 0);
        step(); sw_valid = 1'b0;
        step();
        sw_valid = 1'b1; sw_cmd = 4'd12; #1;
        chk("sw_bad_ready", sw_ready, 1);
        push(FC_IDLE, cyc + 1, 0, 1);
        step(); sw_valid = 1'b0;
        step(); step();

        // Trig coincident with the delayed L1A issues one merged L1A.
        c = cyc; qinj_req = 1'b1; qinj_delay = 9'd10;
        push(FC_CHG_INJ, c + 2, 0, 0); push(FC_L1A, c + 12, 1, 0);
        step(); qinj_req = 1'b0;
        step_to(c + 11); trig = 1'b1;
        step(); trig = 1'b0;
        step_to(c + 15);
`ifdef FCS_STATS_EN
        chk("l1a_count", l1a_count, n_l1a_exp);
        chk("merge_count", merge_count, 1);
`endif

        // Async reset while the delayed L1A is 7 BX away drops it.
        c = cyc; qinj_req = 1'b1; qinj_delay = 9'd20;
        push(FC_CHG_INJ, c + 2, 0, 0);
        step(); qinj_req = 1'b0;
        step_to(c + 14); trig = 1'b1; push(FC_L1A, c + 15, 0, 0);
        step(); trig = 1'b0;
        chk("qbusy_before_rst", qinj_busy, 1);
        @(negedge clk40); #1; rst = 1'b1; #1;
        chk("async_rst_cmd_out", cmd_out, 0);
        chk("async_rst_bcnt", bcnt, 0);
        chk("async_rst_qbusy", qinj_busy, 0);
`ifdef FCS_STATS_EN
        chk("async_rst_l1a_count", l1a_count, 0);
`endif
        step(); step();
        @(negedge clk40); #1; rst = 1'b0;
        step_to(c + 45);
        chk("qbusy_after_rst", qinj_busy, 0);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
